// File: rtl/truth_table_sequencer_pkg.sv
// Shared definitions for the truth-table sequencer: controller state
// encoding, vector count and the golden table of F(A,B,C) = A' + BC.
package truth_table_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam int unsigned NUM_VECTORS = 8;

  // Bit i is F for vector i = {A,B,C}, A as MSB.
  localparam logic [7:0] TT_GOLDEN = 8'h8F;

endpackage

// File: rtl/truth_table_sequencer_logic_fn_unit.sv
// Combinational function unit under characterisation: f = ~a | (b & c).
// Ports: a, b, c - function inputs; f - function output.
module logic_fn_unit (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic f
);

  logic a_n;
  logic b_and_c;

  assign a_n     = ~a;
  assign b_and_c = b & c;
  assign f       = a_n | b_and_c;

endmodule

// File: rtl/truth_table_sequencer.sv
// Self-test controller: on start, walks the function unit through all eight
// input vectors, captures its truth table and compares it with the
// expectation latched at start.
// Ports:
//   clk, rst_n      - clock, synchronous active-low reset
//   start           - run request (accepted only when idle)
//   expect_tt[7:0]  - expected truth table, latched on accept
//   busy, done      - run in progress / one-cycle completion pulse
//   tt[7:0]         - captured truth table
//   pass            - captured table equals expectation
//   mismatch_cnt    - number of mismatching vectors
//   first_bad_idx/_vld - lowest mismatching vector and its valid flag
//   vec_abc         - vector currently applied to the function unit
module truth_table_sequencer
  import truth_table_sequencer_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] expect_tt,
  output logic       busy,
  output logic       done,
  output logic [7:0] tt,
  output logic       pass,
  output logic [3:0] mismatch_cnt,
  output logic [2:0] first_bad_idx,
  output logic       first_bad_vld,
  output logic [2:0] vec_abc
);

  localparam logic [2:0] LAST_IDX    = 3'(NUM_VECTORS - 1);
  localparam logic [3:0] SETTLE_LOAD = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] exp_q, exp_d;
  logic [2:0] vec_q, vec_d;
  logic [7:0] tt_q, tt_d;
  logic [3:0] mm_q, mm_d;
  logic [2:0] fbi_q, fbi_d;
  logic       fbv_q, fbv_d;
  logic       pass_q, pass_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       f;

  logic_fn_unit u_fn (
    .a (vec_q[2]),
    .b (vec_q[1]),
    .c (vec_q[0]),
    .f (f)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    vec_d   = vec_q;
    tt_d    = tt_q;
    mm_d    = mm_q;
    fbi_d   = fbi_q;
    fbv_d   = fbv_q;
    pass_d  = pass_q;
    // Status outputs are registered from the current state, so they trail
    // the state by one cycle (busy starts the cycle after accept).
    busy_d  = (state_q == ST_DRIVE) || (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
    done_d  = (state_q == ST_DONE);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          tt_d    = '0;
          mm_d    = '0;
          fbi_d   = '0;
          fbv_d   = 1'b0;
          pass_d  = 1'b0;
          exp_d   = expect_tt;
          idx_d   = '0;
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        vec_d = idx_q;
        if (SETTLE_CYCLES == 0) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d   = SETTLE_LOAD;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) state_d = ST_SAMPLE;
        else             cnt_d   = cnt_q - 4'd1;
      end
      ST_SAMPLE: begin
        tt_d[idx_q] = f;
        if (f != exp_q[idx_q]) begin
          mm_d = mm_q + 4'd1;
          if (!fbv_q) begin
            fbi_d = idx_q;
            fbv_d = 1'b1;
          end
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = ST_DRIVE;
        end
      end
      ST_DONE: begin
        pass_d  = (mm_q == '0);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      vec_q   <= '0;
      tt_q    <= '0;
      mm_q    <= '0;
      fbi_q   <= '0;
      fbv_q   <= 1'b0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      vec_q   <= vec_d;
      tt_q    <= tt_d;
      mm_q    <= mm_d;
      fbi_q   <= fbi_d;
      fbv_q   <= fbv_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign tt            = tt_q;
  assign pass          = pass_q;
  assign mismatch_cnt  = mm_q;
  assign first_bad_idx = fbi_q;
  assign first_bad_vld = fbv_q;
  assign vec_abc       = vec_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed plus randomized bench for truth_table_sequencer, with a reference
// model built from the function definition and the per-vector timing rule.
module tb_truth_table_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Instance with SETTLE_CYCLES=1 (main), plus 0 and 3 for timing checks.
  logic       start1, start0, start3;
  logic [7:0] expect1, expect0, expect3;
  logic       busy1, busy0, busy3, done1, done0, done3;
  logic [7:0] tt1, tt0, tt3;
  logic       pass1, pass0, pass3;
  logic [3:0] mm1, mm0, mm3;
  logic [2:0] fbi1, fbi0, fbi3;
  logic       fbv1, fbv0, fbv3;
  logic [2:0] vec1, vec0, vec3;

  truth_table_sequencer #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .expect_tt(expect1),
    .busy(busy1), .done(done1), .tt(tt1), .pass(pass1), .mismatch_cnt(mm1),
    .first_bad_idx(fbi1), .first_bad_vld(fbv1), .vec_abc(vec1));

  truth_table_sequencer #(.SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .expect_tt(expect0),
    .busy(busy0), .done(done0), .tt(tt0), .pass(pass0), .mismatch_cnt(mm0),
    .first_bad_idx(fbi0), .first_bad_vld(fbv0), .vec_abc(vec0));

  truth_table_sequencer #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .expect_tt(expect3),
    .busy(busy3), .done(done3), .tt(tt3), .pass(pass3), .mismatch_cnt(mm3),
    .first_bad_idx(fbi3), .first_bad_vld(fbv3), .vec_abc(vec3));

  localparam int P1   = 3;          // cycles per vector at SETTLE_CYCLES=1
  localparam int BUSY1 = 8 * P1;
  localparam int LAT1 = BUSY1 + 1;

  // Reference: F = A' + BC evaluated per vector.
  function automatic logic [7:0] model_tt();
    logic [7:0] r;
    for (int v = 0; v < 8; v++) begin
      logic a, b, c;
      a = ((v >> 2) & 1) != 0;
      b = ((v >> 1) & 1) != 0;
      c = (v & 1) != 0;
      r[v] = !a || (b && c);
    end
    return r;
  endfunction

  function automatic int model_first_bad(input logic [7:0] diff);
    for (int v = 0; v < 8; v++) if (diff[v]) return v;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_results(input string tag, input logic [7:0] e,
                             input logic [7:0] t, input logic p, input logic [3:0] m,
                             input logic [2:0] fi, input logic fv);
    logic [7:0] g;
    logic [7:0] diff;
    int         fb;
    g    = model_tt();
    diff = g ^ e;
    fb   = model_first_bad(diff);
    chk({tag, "_tt"},   32'(t), 32'(g));
    chk({tag, "_mm"},   32'(m), 32'($countones(diff)));
    chk({tag, "_pass"}, 32'(p), 32'(diff == 8'h00));
    chk({tag, "_fbv"},  32'(fv), 32'(fb >= 0));
    if (fb >= 0) chk({tag, "_fbi"}, 32'(fi), 32'(fb));
  endtask

  // One run on the SETTLE_CYCLES=1 instance; expect_tt switches to e_mid
  // mid-run, which must have no effect.
  task automatic run1(input string tag, input logic [7:0] e, input logic [7:0] e_mid, input int mid);
    int vec_bad;
    int busy_bad;
    int done_at;
    int done_cnt;
    @(negedge clk);
    start1  = 1'b1;
    expect1 = e;
    @(posedge clk);          // accept edge, cycle 0
    #1 start1 = 1'b0;
    vec_bad = 0; busy_bad = 0; done_at = -1; done_cnt = 0;
    for (int n = 1; n <= LAT1 + 3; n++) begin
      @(posedge clk); #1;
      if (n == mid) expect1 = e_mid;
      if (busy1 !== (n <= BUSY1)) busy_bad++;
      if (done1 === 1'b1) begin done_cnt++; done_at = n; end
      if (n <= BUSY1 && vec1 !== 3'((n - 1) / P1)) vec_bad++;
    end
    chk({tag, "_done_cyc"}, 32'(done_at), 32'(LAT1));
    chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    chk({tag, "_busy_len"}, 32'(busy_bad), 32'd0);
    chk({tag, "_vec_seq"},  32'(vec_bad), 32'd0);
    chk_results(tag, e, tt1, pass1, mm1, fbi1, fbv1);
  endtask

  initial begin
    int dones;
    int done_pos [$];
    int d0, d3;
    logic [7:0] e0, e3;

    rst_n = 1'b0;
    start1 = 1'b0; start0 = 1'b0; start3 = 1'b0;
    expect1 = '0; expect0 = '0; expect3 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_outs", 32'({tt1, pass1, mm1, fbi1, fbv1, vec1}), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Golden expectation, then expectation changed mid-run, then all wrong.
    run1("golden", 8'h8F, 8'h8F, 0);
    run1("mid_chg", 8'h0F, 8'h8F, 5);
    run1("all_bad", 8'h70, 8'h70, 0);

    // Randomized expectations with random mid-run disturbance.
    for (int i = 0; i < 6; i++) begin
      logic [7:0] e;
      e = 8'($urandom);
      if (i == 0) e = 8'h8F ^ (8'h01 << $urandom_range(7, 0));
      run1("rand", e, 8'($urandom), int'($urandom_range(20, 1)));
    end

    // start held high for 60 cycles: back-to-back runs only.
    @(negedge clk);
    start1 = 1'b1; expect1 = 8'h8F;
    @(posedge clk);          // cycle 0
    dones = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (done1 === 1'b1) begin dones++; done_pos.push_back(n); end
    end
    start1 = 1'b0;
    chk("hold_done_cnt", 32'(dones), 32'd2);
    if (done_pos.size() == 2) begin
      chk("hold_done1_cyc", 32'(done_pos[0]), 32'(LAT1));
      chk("hold_done2_cyc", 32'(done_pos[1]), 32'(2 * LAT1 + 1));
    end
    repeat (30) @(posedge clk);
    #1;
    chk("hold_idle", 32'(busy1), 32'd0);
    chk_results("hold", 8'h8F, tt1, pass1, mm1, fbi1, fbv1);

    // Reset mid-run at vector 4.
    @(negedge clk);
    start1 = 1'b1; expect1 = 8'h00;
    @(posedge clk);
    #1 start1 = 1'b0;
    d0 = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (vec1 === 3'd4) begin d0 = 1; break; end
    end
    chk("rst_mid_reach_v4", 32'(d0), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_busy", 32'(busy1), 32'd0);
    chk("rst_mid_done", 32'(done1), 32'd0);
    chk("rst_mid_outs", 32'({tt1, pass1, mm1, fbi1, fbv1, vec1}), 32'd0);
    rst_n = 1'b1;
    dones = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      if (done1 === 1'b1 || busy1 === 1'b1) dones++;
    end
    chk("rst_mid_no_resume", 32'(dones), 32'd0);
    run1("after_rst", 8'($urandom), 8'($urandom), 7);

    // SETTLE_CYCLES = 0 and 3 latency.
    e0 = 8'($urandom); e3 = 8'h8F;
    @(negedge clk);
    start0 = 1'b1; start3 = 1'b1; expect0 = e0; expect3 = e3;
    @(posedge clk);
    #1 begin start0 = 1'b0; start3 = 1'b0; end
    d0 = -1; d3 = -1;
    for (int n = 1; n <= 45; n++) begin
      @(posedge clk); #1;
      if (done0 === 1'b1 && d0 < 0) d0 = n;
      if (done3 === 1'b1 && d3 < 0) d3 = n;
    end
    chk("s0_done_cyc", 32'(d0), 32'(8 * 2 + 1));
    chk("s3_done_cyc", 32'(d3), 32'(8 * 5 + 1));
    chk_results("s0", e0, tt0, pass0, mm0, fbi0, fbv0);
    chk_results("s3", e3, tt3, pass3, mm3, fbi3, fbv3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
